// File: rtl/multi_dest_packetizer.sv
// Routes deframed rx bytes to per-destination packet streams by their leading
// destination byte, and merges per-destination tx packets onto one frame stream.
module multi_dest_packetizer #(
  parameter int NUM_CHANNELS   = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        rx_frame_tvalid,
  output logic                        rx_frame_tready,
  input  logic [7:0]                  rx_frame_tdata,
  input  logic                        rx_frame_tlast,
  output logic                        tx_frame_tvalid,
  input  logic                        tx_frame_tready,
  output logic [7:0]                  tx_frame_tdata,
  output logic                        tx_frame_tlast,
  output logic [NUM_CHANNELS-1:0]     rx_packet_tvalid,
  input  logic [NUM_CHANNELS-1:0]     rx_packet_tready,
  output logic [7:0]                  rx_packet_tdata,
  output logic                        rx_packet_tlast,
  input  logic [NUM_CHANNELS-1:0]     tx_packet_tvalid,
  output logic [NUM_CHANNELS-1:0]     tx_packet_tready,
  input  logic [8*NUM_CHANNELS-1:0]   tx_packet_tdata,
  input  logic [NUM_CHANNELS-1:0]     tx_packet_tlast,
  output logic [DROP_CNT_WIDTH-1:0]   drop_count
);

  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_PAYLOAD, RX_DISCARD} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_HEADER, TX_PAYLOAD} tx_state_t;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + DROP_CNT_WIDTH'(1);
  endfunction

  rx_state_t       rx_state, rx_state_nxt;
  logic [CH_W-1:0] rx_ch;
  logic            rx_hs, hdr_in_range, hdr_drop;

  assign rx_hs        = rx_frame_tvalid & rx_frame_tready;
  assign hdr_in_range = ({1'b0, rx_frame_tdata} < 9'(NUM_CHANNELS));
  assign hdr_drop     = rx_hs & (rx_state == RX_IDLE) & (rx_frame_tlast | ~hdr_in_range);

  // Rx: header decode and payload demux
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_state   <= RX_IDLE;
      rx_ch      <= '0;
      drop_count <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      if (rx_state == RX_IDLE && rx_hs)
        rx_ch <= rx_frame_tdata[CH_W-1:0];
      if (hdr_drop)
        drop_count <= sat_inc(drop_count);
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:
        if (rx_hs && !rx_frame_tlast)
          rx_state_nxt = hdr_in_range ? RX_PAYLOAD : RX_DISCARD;
      RX_PAYLOAD, RX_DISCARD:
        if (rx_hs && rx_frame_tlast)
          rx_state_nxt = RX_IDLE;
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // aresetn gates IDLE's tready so nothing is accepted while reset is held
  always_comb begin
    rx_frame_tready  = 1'b0;
    rx_packet_tvalid = '0;
    case (rx_state)
      RX_IDLE:    rx_frame_tready = aresetn;
      RX_PAYLOAD: begin
        rx_packet_tvalid[rx_ch] = rx_frame_tvalid;
        rx_frame_tready         = rx_packet_tready[rx_ch];
      end
      RX_DISCARD: rx_frame_tready = 1'b1;
      default:    rx_frame_tready = 1'b0;
    endcase
  end

  assign rx_packet_tdata = rx_frame_tdata;
  assign rx_packet_tlast = rx_frame_tlast;

  tx_state_t       tx_state, tx_state_nxt;
  logic [CH_W-1:0] tx_ptr, tx_grant, arb_pick;
  logic            arb_any, tx_hs;

  assign tx_hs = tx_frame_tvalid & tx_frame_tready;

  // Tx: round-robin search starting just above the last served channel
  always_comb begin
    arb_any  = 1'b0;
    arb_pick = '0;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      if (!arb_any && tx_packet_tvalid[(int'(tx_ptr) + i) % NUM_CHANNELS]) begin
        arb_any  = 1'b1;
        arb_pick = CH_W'((int'(tx_ptr) + i) % NUM_CHANNELS);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tx_state <= TX_IDLE;
      tx_grant <= '0;
      tx_ptr   <= CH_W'(NUM_CHANNELS - 1);
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_state == TX_IDLE && arb_any)
        tx_grant <= arb_pick;
      if (tx_state == TX_PAYLOAD && tx_hs && tx_frame_tlast)
        tx_ptr <= tx_grant;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE:    if (arb_any) tx_state_nxt = TX_HEADER;
      TX_HEADER:  if (tx_frame_tready) tx_state_nxt = TX_PAYLOAD;
      TX_PAYLOAD: if (tx_hs && tx_frame_tlast) tx_state_nxt = TX_IDLE;
      default:    tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_frame_tvalid  = 1'b0;
    tx_frame_tdata   = '0;
    tx_frame_tlast   = 1'b0;
    tx_packet_tready = '0;
    case (tx_state)
      TX_HEADER: begin
        tx_frame_tvalid = 1'b1;
        tx_frame_tdata  = 8'(tx_grant);
      end
      TX_PAYLOAD: begin
        tx_frame_tvalid            = tx_packet_tvalid[tx_grant];
        tx_frame_tdata             = tx_packet_tdata[int'(tx_grant)*8 +: 8];
        tx_frame_tlast             = tx_packet_tlast[tx_grant];
        tx_packet_tready[tx_grant] = tx_frame_tready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_dest_packetizer.sv
// Directed bench for multi_dest_packetizer: rx demux/discard, tx round-robin, reset.
module tb_multi_dest_packetizer;

  localparam int N = 8;

  logic           clk;
  logic           aresetn;
  logic           rx_frame_tvalid, rx_frame_tready, rx_frame_tlast;
  logic [7:0]     rx_frame_tdata;
  logic           tx_frame_tvalid, tx_frame_tready, tx_frame_tlast;
  logic [7:0]     tx_frame_tdata;
  logic [N-1:0]   rx_packet_tvalid, rx_packet_tready;
  logic [7:0]     rx_packet_tdata;
  logic           rx_packet_tlast;
  logic [N-1:0]   tx_packet_tvalid, tx_packet_tready, tx_packet_tlast;
  logic [8*N-1:0] tx_packet_tdata;
  logic [15:0]    drop_count;

  int n_chk = 0;
  int n_fail = 0;

  int         src_pos [N];
  int         src_len [N];
  logic       tx_rdy;
  logic [7:0] cap_d [32];
  logic       cap_l [32];
  int         cap_n;
  logic [N-1:0] rx_cap_ch [16];
  logic [7:0]   rx_cap_d  [16];
  logic         rx_cap_l  [16];
  int           rx_cap_n;

  logic [7:0] exp4_d [12] = '{8'h01, 8'h11, 8'h21, 8'h04, 8'h14, 8'h24,
                              8'h06, 8'h16, 8'h26, 8'h01, 8'h31, 8'h41};
  logic       exp4_l [12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
  logic [7:0] exp6_d [6]  = '{8'h00, 8'h10, 8'h20, 8'h02, 8'h12, 8'h22};
  logic       exp6_l [6]  = '{0, 0, 1, 0, 0, 1};

  multi_dest_packetizer #(.NUM_CHANNELS(N), .DROP_CNT_WIDTH(16)) dut (
    .aclk(clk), .aresetn(aresetn),
    .rx_frame_tvalid(rx_frame_tvalid), .rx_frame_tready(rx_frame_tready),
    .rx_frame_tdata(rx_frame_tdata), .rx_frame_tlast(rx_frame_tlast),
    .tx_frame_tvalid(tx_frame_tvalid), .tx_frame_tready(tx_frame_tready),
    .tx_frame_tdata(tx_frame_tdata), .tx_frame_tlast(tx_frame_tlast),
    .rx_packet_tvalid(rx_packet_tvalid), .rx_packet_tready(rx_packet_tready),
    .rx_packet_tdata(rx_packet_tdata), .rx_packet_tlast(rx_packet_tlast),
    .tx_packet_tvalid(tx_packet_tvalid), .tx_packet_tready(tx_packet_tready),
    .tx_packet_tdata(tx_packet_tdata), .tx_packet_tlast(tx_packet_tlast),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one rx byte for one cycle and log any packet-side handshake.
  task automatic rx_drive(input logic [7:0] d, input logic l, input logic [N-1:0] rdy);
    @(negedge clk);
    rx_frame_tvalid  = 1'b1;
    rx_frame_tdata   = d;
    rx_frame_tlast   = l;
    rx_packet_tready = rdy;
    #1;
    if ((rx_packet_tvalid & rx_packet_tready) != '0 && rx_cap_n < 16) begin
      rx_cap_ch[rx_cap_n] = rx_packet_tvalid;
      rx_cap_d[rx_cap_n]  = rx_packet_tdata;
      rx_cap_l[rx_cap_n]  = rx_packet_tlast;
      rx_cap_n++;
    end
  endtask

  task automatic rx_idle();
    @(negedge clk);
    rx_frame_tvalid = 1'b0;
    #1;
  endtask

  // One cycle of the tx source model; byte k of channel c is 0x10*(k+1)+c.
  task automatic tx_step();
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      tx_packet_tvalid[c]       = (src_pos[c] < src_len[c]);
      tx_packet_tdata[8*c +: 8] = 8'(16 * (src_pos[c] + 1) + c);
      tx_packet_tlast[c]        = (src_pos[c] % 2 == 1);
    end
    tx_frame_tready = tx_rdy;
    #1;
    if (tx_frame_tvalid && tx_frame_tready && cap_n < 32) begin
      cap_d[cap_n] = tx_frame_tdata;
      cap_l[cap_n] = tx_frame_tlast;
      cap_n++;
    end
    for (int c = 0; c < N; c++)
      if (tx_packet_tvalid[c] && tx_packet_tready[c]) src_pos[c]++;
  endtask

  task automatic src_clear();
    for (int c = 0; c < N; c++) begin
      src_pos[c] = 0;
      src_len[c] = 0;
    end
    cap_n = 0;
  endtask

  initial begin
    aresetn          = 1'b1;
    rx_frame_tvalid  = 1'b0;
    rx_frame_tdata   = '0;
    rx_frame_tlast   = 1'b0;
    rx_packet_tready = '1;
    tx_frame_tready  = 1'b0;
    tx_packet_tvalid = '0;
    tx_packet_tdata  = '0;
    tx_packet_tlast  = '0;
    tx_rdy           = 1'b1;
    rx_cap_n         = 0;
    src_clear();

    #2 aresetn = 1'b0;
    #1;
    chk("rst_rx_frame_tready", rx_frame_tready, 0);
    chk("rst_rx_packet_tvalid", rx_packet_tvalid, 0);
    chk("rst_tx_frame_tvalid", tx_frame_tvalid, 0);
    chk("rst_tx_packet_tready", tx_packet_tready, 0);
    chk("rst_drop_count", drop_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    chk("post_rst_rx_frame_tready", rx_frame_tready, 1);

    // Frame to channel 3
    rx_drive(8'h03, 1'b0, '1);
    chk("t1_hdr_tready", rx_frame_tready, 1);
    chk("t1_hdr_tvalid", rx_packet_tvalid, 0);
    rx_drive(8'hAA, 1'b0, '1);
    chk("t1_aa_tvalid", rx_packet_tvalid, 8'h08);
    chk("t1_aa_tdata", rx_packet_tdata, 8'hAA);
    chk("t1_aa_tlast", rx_packet_tlast, 0);
    rx_drive(8'hBB, 1'b1, '1);
    chk("t1_bb_tvalid", rx_packet_tvalid, 8'h08);
    chk("t1_bb_tdata", rx_packet_tdata, 8'hBB);
    chk("t1_bb_tlast", rx_packet_tlast, 1);
    rx_idle();
    chk("t1_idle_tvalid", rx_packet_tvalid, 0);
    chk("t1_drop", drop_count, 0);
    chk("t1_count", rx_cap_n, 2);

    // Out-of-range and header-only frames, then a good frame to channel 0
    rx_cap_n = 0;
    rx_drive(8'h09, 1'b0, '1);
    rx_drive(8'h11, 1'b0, '1);
    chk("t2_disc_tvalid", rx_packet_tvalid, 0);
    chk("t2_disc_tready", rx_frame_tready, 1);
    chk("t2_drop1", drop_count, 1);
    rx_drive(8'h22, 1'b1, '1);
    chk("t2_disc_last_tvalid", rx_packet_tvalid, 0);
    rx_drive(8'h05, 1'b1, '1);
    chk("t2_hdronly_tvalid", rx_packet_tvalid, 0);
    rx_drive(8'h00, 1'b0, '1);
    chk("t2_drop2", drop_count, 2);
    rx_drive(8'h33, 1'b1, '1);
    chk("t2_ch0_tvalid", rx_packet_tvalid, 8'h01);
    chk("t2_ch0_tdata", rx_packet_tdata, 8'h33);
    rx_idle();
    chk("t2_count", rx_cap_n, 1);
    chk("t2_drop_final", drop_count, 2);

    // Channel 2 with ready toggling 1,0,0,1
    rx_cap_n = 0;
    rx_drive(8'h02, 1'b0, '1);
    rx_drive(8'h51, 1'b0, '1);
    chk("t3_c1_tready", rx_frame_tready, 1);
    chk("t3_c1_tvalid", rx_packet_tvalid, 8'h04);
    rx_drive(8'h52, 1'b1, 8'hFB);
    chk("t3_c2_tready", rx_frame_tready, 0);
    chk("t3_c2_tvalid", rx_packet_tvalid, 8'h04);
    rx_drive(8'h52, 1'b1, 8'hFB);
    chk("t3_c3_tready", rx_frame_tready, 0);
    rx_drive(8'h52, 1'b1, '1);
    chk("t3_c4_tready", rx_frame_tready, 1);
    rx_idle();
    chk("t3_count", rx_cap_n, 2);
    chk("t3_d0", rx_cap_d[0], 8'h51);
    chk("t3_l0", rx_cap_l[0], 0);
    chk("t3_ch0", rx_cap_ch[0], 8'h04);
    chk("t3_d1", rx_cap_d[1], 8'h52);
    chk("t3_l1", rx_cap_l[1], 1);
    chk("t3_ch1", rx_cap_ch[1], 8'h04);
    chk("t3_idle_tvalid", rx_packet_tvalid, 0);

    // Round robin over channels 1, 4, 6 with channel 1 re-requesting
    src_clear();
    src_len[1] = 4;
    src_len[4] = 2;
    src_len[6] = 2;
    tx_rdy = 1'b1;
    repeat (24) tx_step();
    chk("t4_count", cap_n, 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t4_d%0d", i), cap_d[i], exp4_d[i]);
      chk($sformatf("t4_l%0d", i), cap_l[i], exp4_l[i]);
    end
    chk("t4_idle_tvalid", tx_frame_tvalid, 0);

    // Header stall on channel 4
    src_clear();
    src_len[4] = 2;
    tx_rdy = 1'b0;
    tx_step();
    chk("t5_arb_tvalid", tx_frame_tvalid, 0);
    for (int i = 0; i < 5; i++) begin
      tx_step();
      chk($sformatf("t5_hold%0d_tvalid", i), tx_frame_tvalid, 1);
      chk($sformatf("t5_hold%0d_tdata", i), tx_frame_tdata, 8'h04);
      chk($sformatf("t5_hold%0d_tlast", i), tx_frame_tlast, 0);
      chk($sformatf("t5_hold%0d_ready", i), tx_packet_tready, 0);
    end
    tx_rdy = 1'b1;
    repeat (4) tx_step();
    chk("t5_count", cap_n, 3);
    chk("t5_d0", cap_d[0], 8'h04);
    chk("t5_d1", cap_d[1], 8'h14);
    chk("t5_d2", cap_d[2], 8'h24);
    chk("t5_l2", cap_l[2], 1);

    // Reset mid-payload on both paths
    src_clear();
    src_len[0] = 4;
    rx_drive(8'h01, 1'b0, '1);
    rx_drive(8'h77, 1'b0, '0);
    chk("t6_rx_mid_tvalid", rx_packet_tvalid, 8'h02);
    repeat (3) tx_step();
    chk("t6_tx_mid_tvalid", tx_frame_tvalid, 1);
    chk("t6_tx_mid_ready", tx_packet_tready, 8'h01);
    rx_packet_tready = '1;
    aresetn = 1'b0;
    #1;
    chk("t6_rst_rx_tvalid", rx_packet_tvalid, 0);
    chk("t6_rst_rx_tready", rx_frame_tready, 0);
    chk("t6_rst_tx_tvalid", tx_frame_tvalid, 0);
    chk("t6_rst_tx_ready", tx_packet_tready, 0);
    chk("t6_rst_drop", drop_count, 0);
    @(posedge clk);
    @(negedge clk);
    rx_frame_tvalid  = 1'b0;
    tx_packet_tvalid = '0;
    aresetn          = 1'b1;
    src_clear();
    rx_cap_n = 0;
    rx_drive(8'h00, 1'b0, '1);
    rx_drive(8'h5A, 1'b1, '1);
    chk("t6_rx_tvalid", rx_packet_tvalid, 8'h01);
    chk("t6_rx_tdata", rx_packet_tdata, 8'h5A);
    chk("t6_rx_tlast", rx_packet_tlast, 1);
    rx_idle();
    chk("t6_rx_count", rx_cap_n, 1);
    src_len[0] = 2;
    src_len[2] = 2;
    repeat (12) tx_step();
    chk("t6_tx_count", cap_n, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t6_d%0d", i), cap_d[i], exp6_d[i]);
      chk($sformatf("t6_l%0d", i), cap_l[i], exp6_l[i]);
    end
    chk("t6_drop_final", drop_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_dest_packetizer.md
Name: multi_dest_packetizer

Overview:
- Parametrised successor of the single-stream destination packetizer in the UART-to-AXI4 bridge. Sits between framing and the per-destination command engines.
- Rx side: strips the leading destination byte of each frame and demultiplexes the payload onto NUM_CHANNELS independent packet streams. Out-of-range and empty frames are discarded and counted.
- Tx side: round-robin arbitrates NUM_CHANNELS packet streams, prepends the winning channel's destination byte and forwards the packet whole onto the single tx frame stream.

Parameters:
NUM_CHANNELS  8  number of destination channels, legal range 1..256
DROP_CNT_WIDTH  16  width of the saturating discarded-frame counter

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous, active-low
rx_frame_tvalid  in  1  deframed byte stream from framing, valid
rx_frame_tready  out  1  ready
rx_frame_tdata  in  8  byte
rx_frame_tlast  in  1  last byte of frame
tx_frame_tvalid  out  1  byte stream to framing, valid
tx_frame_tready  in  1  ready
tx_frame_tdata  out  8  byte
tx_frame_tlast  out  1  last byte of frame
rx_packet_tvalid  out  NUM_CHANNELS  per-channel valid, one-hot or zero
rx_packet_tready  in  NUM_CHANNELS  per-channel ready
rx_packet_tdata  out  8  shared payload byte
rx_packet_tlast  out  1  shared last flag
tx_packet_tvalid  in  NUM_CHANNELS  per-channel valid
tx_packet_tready  out  NUM_CHANNELS  per-channel ready, one-hot or zero
tx_packet_tdata  in  8*NUM_CHANNELS  channel c occupies bits [8c+7:8c]
tx_packet_tlast  in  NUM_CHANNELS  per-channel last flag
drop_count  out  DROP_CNT_WIDTH  count of discarded rx frames, saturating

Behaviour:
- Reset: async assert forces both FSMs to IDLE and abandons any partial frame.
  - All valid/ready outputs 0 during reset, except rx_frame_tready = 1 from the first cycle after deassertion (IDLE).
  - drop_count = 0; round-robin pointer = NUM_CHANNELS-1, so channel 0 has first priority.
- Rx FSM states: IDLE, PAYLOAD, DISCARD.
  - IDLE: rx_frame_tready = 1; all rx_packet_tvalid = 0. On a header handshake, evaluate in this order:
    - tlast = 1 (header-only frame): stay IDLE, drop_count +1.
    - tdata >= NUM_CHANNELS: go to DISCARD, drop_count +1.
    - Otherwise: latch channel = tdata and go to PAYLOAD.
  - PAYLOAD: zero-latency pass-through.
    - rx_packet_tvalid[ch] = rx_frame_tvalid; rx_frame_tready = rx_packet_tready[ch].
    - rx_packet_tdata and rx_packet_tlast follow the input.
    - Handshake with tlast = 1 returns the FSM to IDLE.
  - DISCARD: rx_frame_tready = 1; a handshake with tlast = 1 returns the FSM to IDLE.
  - Header handling costs exactly one accepted byte/cycle. Back-to-back frames incur no extra bubble beyond the header.
  - drop_count saturates at all-ones.
- Tx FSM states: IDLE, HEADER, PAYLOAD.
  - IDLE: if any tx_packet_tvalid is set, grant the first requesting channel searching upward from pointer+1 modulo NUM_CHANNELS. Register the grant and go to HEADER. Arbitration latency is 1 cycle; no tready is asserted in IDLE.
  - HEADER: tx_frame_tvalid = 1, tdata = grant zero-extended to 8 bits, tlast = 0.
    - Must hold stable until tx_frame_tready.
    - On handshake go to PAYLOAD.
  - PAYLOAD: zero-latency pass-through from the granted channel.
    - tx_packet_tready[grant] = tx_frame_tready; all other channels' tready = 0.
    - Handshake with tlast = 1: pointer = grant, return to IDLE.
  - A granted channel keeps the grant until its tlast; no preemption.
  - Channels deasserting tvalid mid-packet simply stall the output.
- Rx and Tx paths are fully independent; simultaneous activity on both is legal.
- NUM_CHANNELS = 1: the pointer logic degenerates and channel 0 is always granted.

Test Plan:
- Rx frame {03, AA, BB(tlast)}, all channels ready → channel 3 only sees AA then BB with tlast; drop_count stays 0; other rx_packet_tvalid bits stay 0.
- Rx frames {09, 11, 22(tlast)} then {05(tlast)} with NUM_CHANNELS = 8 → both frames consumed with no outputs; drop_count = 2. Following frame {00, 33(tlast)} is delivered on channel 0.
- Rx frame to channel 2 with rx_packet_tready[2] toggling 1,0,0,1 → no data lost or duplicated; rx_frame_tready mirrors rx_packet_tready[2].
- Tx: channels 1, 4, 6 all hold 2-byte packets at once → frames emitted in order {01,..}, {04,..}, {06,..}. Channel 1 re-requesting after its packet is served only after 6.
- Tx with tx_frame_tready low for 5 cycles during HEADER → header byte 0x04 held stable with tlast = 0 throughout; no tx_packet_tready asserted.
- aresetn pulsed low mid-payload on both paths → all valid/ready outputs drop immediately and drop_count = 0. After release, a fresh frame to channel 0 on each path is handled correctly.
